// File: rtl/cpu_types.sv
// cpu_types
// Shared types for the 4-thread barrel core writeback path.
// Contents:
//   XLEN, rs_addr_t   - datapath width and register address type
//   thread_id_t       - hardware thread id (2 bits)
//   NUM_THREADS       - thread count of the barrel core
//   wb_entry_t        - buffered result {thread, rd, data, killed}
//   rotDist()         - distance from a priority pointer in rotating order
package cpu_types;

  localparam int XLEN        = 32;
  localparam int RS_ADDR_W   = 5;
  localparam int NUM_THREADS = 4;

  typedef logic [RS_ADDR_W-1:0]             rs_addr_t;
  typedef logic [$clog2(NUM_THREADS)-1:0]   thread_id_t;

  typedef struct packed {
    thread_id_t      thread;
    rs_addr_t        rd;
    logic [XLEN-1:0] data;
    logic            killed;
  } wb_entry_t;

  // How many steps source idx sits behind base when walking upward with wrap.
  // The arbiter grants the live source with the smallest distance.
  function automatic int rotDist(input int idx, input int base, input int n);
    return (idx >= base) ? (idx - base) : (idx - base + n);
  endfunction

endpackage

// File: rtl/writeback_fifo.sv
// writeback_fifo
// Per-source result buffer for the writeback arbiter. Holds DEPTH entries
// (DEPTH a power of 2, at least 2) and can mark every stored entry of one
// thread as killed, so flushed results drain without writing.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   i_push, i_entry     - write i_entry at the tail (caller guarantees !o_full)
//   i_pop               - drop the head (caller guarantees !o_empty)
//   i_killValid,
//   i_killThread        - mark entries of this thread killed, including a
//                         same-cycle push of that thread
//   o_head              - current head entry
//   o_full, o_empty     - occupancy flags from the registered count
module writeback_fifo
  import cpu_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  wb_entry_t  i_entry,
  input  logic       i_pop,
  input  logic       i_killValid,
  input  thread_id_t i_killThread,
  output wb_entry_t  o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  wb_entry_t        w_pushEntry;

  // An entry arriving in the same cycle as a flush of its thread is still
  // accepted, but it goes in already killed so it drains silently later.
  always_comb begin
    w_pushEntry        = i_entry;
    w_pushEntry.killed = i_entry.killed | (i_killValid && (i_entry.thread == i_killThread));
  end

  // Storage, pointers and count. Kill marking touches every slot; the slot
  // being pushed is free, so the later push assignment is the one that counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_killValid && (r_mem[k].thread == i_killThread)) begin
          r_mem[k].killed <= 1'b1;
        end
      end
      if (i_push) begin
        r_mem[r_wrPtr] <= w_pushEntry;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Collects results from NUM_SRC execution units, buffers them per source and
// drives the single register-file write port, at most one write per cycle,
// with rotating priority. Flushed results and writes to x0 are dropped.
// Parameters: NUM_SRC (>= 2), FIFO_DEPTH (power of 2, >= 2)
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   src_valid/src_ready        - per-source handshake
//   src_thread/src_rd/src_data - per-source result, packed source 0 in LSBs
//   flush_valid/flush_thread   - kill all buffered results of one thread
//   thread_rd_id/rd_addr/
//   new_data/wr_en             - registered register-file write port
// Optional build macro WRITEBACK_BYPASS_EN adds bypass_valid, bypass_thread,
// bypass_addr and bypass_data, mirroring the write port for the read stage.
module writeback_arbiter
  import cpu_types::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*2-1:0]         src_thread,
  input  logic [NUM_SRC*RS_ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]      src_data,
  input  logic                         flush_valid,
  input  logic [1:0]                   flush_thread,
  output logic [1:0]                   thread_rd_id,
  output logic [RS_ADDR_W-1:0]         rd_addr,
  output logic [XLEN-1:0]              new_data,
  output logic                         wr_en
`ifdef WRITEBACK_BYPASS_EN
  ,
  output logic                         bypass_valid,
  output logic [1:0]                   bypass_thread,
  output logic [RS_ADDR_W-1:0]         bypass_addr,
  output logic [XLEN-1:0]              bypass_data
`endif
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  wb_entry_t             w_head [NUM_SRC];
  logic [NUM_SRC-1:0]    w_full;
  logic [NUM_SRC-1:0]    w_empty;
  logic [NUM_SRC-1:0]    w_push;
  logic [NUM_SRC-1:0]    w_pop;
  logic [NUM_SRC-1:0]    w_dead;
  logic [NUM_SRC-1:0]    w_live;

  logic                  w_grantValid;
  logic [SRC_W-1:0]      w_grantIdx;
  int                    w_bestDist;
  thread_id_t            w_grantThread;
  rs_addr_t              w_grantRd;
  logic [XLEN-1:0]       w_grantData;
  logic [SRC_W-1:0]      w_nextPrio;

  logic [SRC_W-1:0]      r_prio;
  logic                  r_wrEn;
  thread_id_t            r_thread;
  rs_addr_t              r_addr;
  logic [XLEN-1:0]       r_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_entry_t w_inEntry;

    assign w_inEntry = '{thread: src_thread[g*2 +: 2],
                         rd:     src_rd[g*RS_ADDR_W +: RS_ADDR_W],
                         data:   src_data[g*XLEN +: XLEN],
                         killed: 1'b0};

    // Ready comes from the registered count alone; a pop in the same cycle
    // does not free a slot until the next cycle.
    assign src_ready[g] = ~w_full[g];
    assign w_push[g]    = src_valid[g] & ~w_full[g];

    writeback_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push[g]),
      .i_entry      (w_inEntry),
      .i_pop        (w_pop[g]),
      .i_killValid  (flush_valid),
      .i_killThread (flush_thread),
      .o_head       (w_head[g]),
      .o_full       (w_full[g]),
      .o_empty      (w_empty[g])
    );

    // A same-cycle flush of the head's thread makes it dead at once, so a
    // flush always beats a grant of a matching head.
    assign w_dead[g] = ~w_empty[g] &
                       (w_head[g].killed | (w_head[g].rd == '0) |
                        (flush_valid & (w_head[g].thread == flush_thread)));
    assign w_live[g] = ~w_empty[g] & ~w_dead[g];

    // Dead heads drain alongside whichever live head wins the grant.
    assign w_pop[g]  = w_dead[g] | (w_grantValid & (w_grantIdx == SRC_W'(g)));
  end

  // Rotating priority: the live head nearest to r_prio (walking upward with
  // wrap) wins. The winner's fields are captured here so the output
  // registers never index the head array with the grant index.
  always_comb begin
    w_grantValid  = 1'b0;
    w_grantIdx    = '0;
    w_bestDist    = NUM_SRC;
    w_grantThread = '0;
    w_grantRd     = '0;
    w_grantData   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_live[i] && (rotDist(i, int'(r_prio), NUM_SRC) < w_bestDist)) begin
        w_bestDist    = rotDist(i, int'(r_prio), NUM_SRC);
        w_grantValid  = 1'b1;
        w_grantIdx    = SRC_W'(i);
        w_grantThread = w_head[i].thread;
        w_grantRd     = w_head[i].rd;
        w_grantData   = w_head[i].data;
      end
    end
  end

  // The source after the winner gets highest priority next; wrap explicitly
  // so non power-of-2 source counts also work.
  always_comb begin
    w_nextPrio = (w_grantIdx == LAST_SRC) ? '0 : (w_grantIdx + SRC_W'(1));
  end

  // Write-port registers and priority pointer. Without a grant the strobe
  // drops while address/data/thread hold, and the pointer stays put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrEn   <= 1'b0;
      r_thread <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_prio   <= '0;
    end else begin
      r_wrEn <= w_grantValid;
      if (w_grantValid) begin
        r_thread <= w_grantThread;
        r_addr   <= w_grantRd;
        r_data   <= w_grantData;
        r_prio   <= w_nextPrio;
      end
    end
  end

  assign wr_en        = r_wrEn;
  assign thread_rd_id = r_thread;
  assign rd_addr      = r_addr;
  assign new_data     = r_data;

`ifdef WRITEBACK_BYPASS_EN
  assign bypass_valid  = r_wrEn;
  assign bypass_thread = r_thread;
  assign bypass_addr   = r_addr;
  assign bypass_data   = r_data;
`endif

endmodule
